// File: rtl/pc_gen.sv
// Fetch-stage program counter: sequential advance on accepted requests,
// redirect/trap reload, stall freeze and a BOOT/RUN/HALT control machine.
module pc_gen #(
    parameter int unsigned          XLEN         = 32,
    parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]      TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned          INC          = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redir_valid_i,
    input  logic [XLEN-1:0] redir_target_i,
    input  logic            trap_i,
    input  logic            halt_i,
    input  logic            resume_i,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_next_seq_o,
    output logic            misalign_o,
    output logic            halted_o
);

    localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);
    localparam logic [XLEN-1:0] BIT0_CLR   = ~XLEN'(1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_misalign;
    logic            r_halted;

    logic            w_active;
    logic            w_req_valid;
    logic [XLEN-1:0] w_redir_pc;
    logic [XLEN-1:0] w_pc_inc;

    assign w_active    = (r_state != ST_BOOT);
    assign w_req_valid = (r_state == ST_RUN) && !stall_i;
    assign w_redir_pc  = redir_target_i & BIT0_CLR;
    assign w_pc_inc    = r_pc + INC_W;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_VECTOR;
            r_state    <= ST_BOOT;
            r_misalign <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_misalign <= 1'b0;

            case (r_state)
                ST_BOOT: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
                ST_RUN: begin
                    if (halt_i) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (trap_i || resume_i) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_BOOT;
                    r_halted <= 1'b0;
                end
            endcase

            // Trap outranks redirect, which outranks stall and the
            // sequential advance; HALT blocks advance via w_req_valid.
            if (w_active) begin
                if (trap_i) begin
                    r_pc <= TRAP_VECTOR;
                end else if (redir_valid_i) begin
                    r_pc       <= w_redir_pc;
                    r_misalign <= |(w_redir_pc & ALIGN_MASK);
                end else if (w_req_valid && req_ready_i) begin
                    r_pc <= w_pc_inc;
                end
            end
        end
    end

    assign req_valid_o   = w_req_valid;
    assign pc_o          = r_pc;
    assign pc_next_seq_o = w_pc_inc;
    assign misalign_o    = r_misalign;
    assign halted_o      = r_halted;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, a bounded boot
// latency probe, then randomized traffic against a rule-level reference model.
module tb_pc_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, stall_i, redir_valid_i, trap_i, halt_i, resume_i, req_ready_i;
    logic [31:0] redir_target_i;
    logic        req_valid_o, misalign_o, halted_o;
    logic [31:0] pc_o, pc_next_seq_o;

    int checks   = 0;
    int failures = 0;

    pc_gen #(
        .XLEN        (32),
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0100),
        .INC         (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redir_valid_i (redir_valid_i),
        .redir_target_i(redir_target_i),
        .trap_i        (trap_i),
        .halt_i        (halt_i),
        .resume_i      (resume_i),
        .req_valid_o   (req_valid_o),
        .req_ready_i   (req_ready_i),
        .pc_o          (pc_o),
        .pc_next_seq_o (pc_next_seq_o),
        .misalign_o    (misalign_o),
        .halted_o      (halted_o)
    );

    typedef struct {
        logic        rst, stall, rv, trap, halt, res, rdy;
        logic [31:0] tgt;
        logic        erv;
        logic [31:0] epc;
        logic        ehalt, emis;
    } vec_t;

    vec_t tbl[32];

    function automatic vec_t mk(input logic r, s, v, input logic [31:0] t,
                                input logic tr, h, re, rd,
                                input logic erv, input logic [31:0] epc,
                                input logic eh, em);
        vec_t x;
        x.rst = r; x.stall = s; x.rv = v; x.tgt = t; x.trap = tr;
        x.halt = h; x.res = re; x.rdy = rd;
        x.erv = erv; x.epc = epc; x.ehalt = eh; x.emis = em;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, s, v, input logic [31:0] t,
                         input logic tr, h, re, rd);
        rst_n = r; stall_i = s; redir_valid_i = v; redir_target_i = t;
        trap_i = tr; halt_i = h; resume_i = re; req_ready_i = rd;
    endtask

    // Reference model state: mode 0=boot, 1=run, 2=halt
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_halt, m_mis;

    initial begin
        logic [31:0] prev_pc;
        int          n;

        drive(0, 0, 0, 32'h0, 0, 0, 0, 1);
        @(posedge clk);

        //              rst st rv tgt           tr h  re rd   erv epc           eh em
        tbl[0]  = mk(0, 0, 0, 32'h0,        0, 0, 0, 1,  0, 32'h0,        0, 0);
        tbl[1]  = mk(1, 0, 0, 32'h0,        0, 0, 0, 1,  0, 32'h0,        0, 0);
        tbl[2]  = mk(1, 0, 0, 32'h0,        0, 0, 0, 1,  1, 32'h4,        0, 0);
        tbl[3]  = mk(1, 0, 0, 32'h0,        0, 0, 0, 1,  1, 32'h8,        0, 0);
        tbl[4]  = mk(1, 0, 0, 32'h0,        0, 0, 0, 1,  1, 32'hC,        0, 0);
        tbl[5]  = mk(1, 0, 0, 32'h0,        0, 0, 0, 1,  1, 32'h10,       0, 0);
        tbl[6]  = mk(1, 0, 0, 32'h0,        0, 0, 0, 0,  1, 32'h10,       0, 0);
        tbl[7]  = mk(1, 0, 0, 32'h0,        0, 0, 0, 0,  1, 32'h10,       0, 0);
        tbl[8]  = mk(1, 0, 0, 32'h0,        0, 0, 0, 0,  1, 32'h10,       0, 0);
        tbl[9]  = mk(1, 1, 0, 32'h0,        0, 0, 0, 1,  0, 32'h10,       0, 0);
        tbl[10] = mk(1, 0, 0, 32'h0,        0, 0, 0, 1,  1, 32'h14,       0, 0);
        tbl[11] = mk(1, 1, 1, 32'h203,      0, 0, 0, 0,  0, 32'h202,      0, 1);
        tbl[12] = mk(1, 0, 0, 32'h0,        0, 0, 0, 0,  1, 32'h202,      0, 0);
        tbl[13] = mk(1, 0, 1, 32'h200,      0, 0, 0, 1,  1, 32'h200,      0, 0);
        tbl[14] = mk(1, 0, 1, 32'h400,      1, 0, 0, 1,  1, 32'h100,      0, 0);
        tbl[15] = mk(1, 0, 1, 32'h20,       0, 0, 0, 0,  1, 32'h20,       0, 0);
        tbl[16] = mk(1, 0, 0, 32'h0,        0, 1, 0, 1,  1, 32'h24,       1, 0);
        tbl[17] = mk(1, 0, 0, 32'h0,        0, 0, 0, 1,  0, 32'h24,       1, 0);
        tbl[18] = mk(1, 0, 0, 32'h0,        0, 0, 0, 1,  0, 32'h24,       1, 0);
        tbl[19] = mk(1, 0, 0, 32'h0,        0, 0, 1, 1,  0, 32'h24,       0, 0);
        tbl[20] = mk(1, 0, 0, 32'h0,        0, 0, 0, 1,  1, 32'h28,       0, 0);
        tbl[21] = mk(1, 0, 0, 32'h0,        0, 1, 0, 0,  1, 32'h28,       1, 0);
        tbl[22] = mk(1, 0, 1, 32'h33,       0, 0, 0, 1,  0, 32'h32,       1, 1);
        tbl[23] = mk(1, 0, 0, 32'h0,        1, 0, 0, 1,  0, 32'h100,      0, 0);
        tbl[24] = mk(1, 0, 0, 32'h0,        0, 0, 0, 1,  1, 32'h104,      0, 0);
        tbl[25] = mk(1, 0, 0, 32'h0,        1, 1, 0, 1,  1, 32'h100,      1, 0);
        tbl[26] = mk(1, 0, 0, 32'h0,        0, 0, 1, 1,  0, 32'h100,      0, 0);
        tbl[27] = mk(1, 0, 1, 32'hFFFF_FFFC,0, 0, 0, 0,  1, 32'hFFFF_FFFC,0, 0);
        tbl[28] = mk(1, 0, 0, 32'h0,        0, 0, 0, 1,  1, 32'h0,        0, 0);
        tbl[29] = mk(0, 0, 1, 32'h400,      1, 0, 0, 1,  1, 32'h0,        0, 0);
        tbl[30] = mk(1, 0, 0, 32'h0,        0, 0, 0, 1,  0, 32'h0,        0, 0);
        tbl[31] = mk(1, 0, 0, 32'h0,        0, 0, 0, 1,  1, 32'h4,        0, 0);

        prev_pc = 32'h0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].stall, tbl[i].rv, tbl[i].tgt,
                  tbl[i].trap, tbl[i].halt, tbl[i].res, tbl[i].rdy);
            #1;
            chk($sformatf("vec%0d_req_valid", i), req_valid_o, tbl[i].erv);
            chk($sformatf("vec%0d_pc_next_seq", i), pc_next_seq_o, prev_pc + 32'd4);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_pc", i), pc_o, tbl[i].epc);
            chk($sformatf("vec%0d_halted", i), halted_o, tbl[i].ehalt);
            chk($sformatf("vec%0d_misalign", i), misalign_o, tbl[i].emis);
            prev_pc = tbl[i].epc;
        end

        // Boot latency: first request must appear exactly one cycle after release.
        @(negedge clk);
        drive(0, 0, 0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 32'h0, 0, 0, 0, 0);
        n = 0;
        while (n < 9) begin
            #1;
            if (req_valid_o === 1'b1) break;
            n++;
            @(negedge clk);
        end
        chk("boot_latency", n, 1);
        chk("boot_pc", pc_o, 32'h0);

        m_mode = 1; m_pc = 32'h0; m_halt = 1'b0; m_mis = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic        r, s, v, tr, h, re, rd, erv;
            logic [31:0] t;
            int          old_mode;
            @(negedge clk);
            r  = ($urandom_range(63) != 0);
            s  = ($urandom_range(3) == 0);
            v  = ($urandom_range(7) == 0);
            tr = ($urandom_range(15) == 0);
            h  = ($urandom_range(15) == 0);
            re = ($urandom_range(5) == 0);
            rd = ($urandom_range(3) != 0);
            t  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                          : 32'($urandom);
            drive(r, s, v, t, tr, h, re, rd);
            erv = (m_mode == 1) && !s;
            #1;
            chk($sformatf("rnd%0d_req_valid", c), req_valid_o, erv);
            chk($sformatf("rnd%0d_pc_next_seq", c), pc_next_seq_o, m_pc + 32'd4);

            if (!r) begin
                m_mode = 0; m_pc = 32'h0; m_mis = 1'b0;
            end else begin
                old_mode = m_mode;
                m_mis = 1'b0;
                if (old_mode == 0)                   m_mode = 1;
                else if (old_mode == 1 && h)         m_mode = 2;
                else if (old_mode == 2 && (tr || re)) m_mode = 1;
                if (old_mode != 0) begin
                    if (tr) m_pc = 32'h100;
                    else if (v) begin
                        m_pc  = t - (t % 2);
                        m_mis = (m_pc % 4) != 0;
                    end else if (erv && rd) m_pc = m_pc + 32'd4;
                end
            end
            m_halt = (m_mode == 2);

            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_pc", c), pc_o, m_pc);
            chk($sformatf("rnd%0d_halted", c), halted_o, m_halt);
            chk($sformatf("rnd%0d_misalign", c), misalign_o, m_mis);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
